// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
// Shared constants for the carry-lookahead adder slice.
//   WIDTH_DEFAULT : default operand/sum width of the adder
//   GROUP         : bits per first-level lookahead group (cla4)
// ----------------------------------------------------------------------------
package adder_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int GROUP         = 4;

endpackage : adder_pkg

// File: rtl/adder_if.sv
// ----------------------------------------------------------------------------
// adder_if
// Operand/result bundle between a requester and the adder.
//   in_valid, a, b, sub : operation request (driven by master)
//   s, out_valid, cout, ovf, zero : registered result (driven by slave)
// ----------------------------------------------------------------------------
interface adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;

    logic [WIDTH-1:0] s;
    logic             out_valid;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub,
        input  s, out_valid, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub,
        output s, out_valid, cout, ovf, zero
    );

endinterface : adder_if

// File: rtl/adder_cla4.sv
// ----------------------------------------------------------------------------
// cla4
// One 4-bit carry-lookahead group. All internal carries are formed directly
// from generate/propagate terms and the group carry-in, so there is no ripple
// inside the group.
//   i_a, i_b : group operand bits (i_b already inverted for subtraction)
//   i_cin    : carry into bit 0 of the group
//   o_sum    : group sum bits
//   o_gg     : group generate  (group produces a carry regardless of cin)
//   o_gp     : group propagate (group passes cin through to its carry-out)
// ----------------------------------------------------------------------------
module cla4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_gg,
    output logic       o_gp
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum = w_p ^ w_c;

    assign o_gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign o_gp = &w_p;

endmodule : cla4

// File: rtl/adder.sv
// ----------------------------------------------------------------------------
// adder
// Registered WIDTH-bit add/subtract with one cycle of latency and one
// operation accepted per cycle. Two-level carry lookahead: WIDTH/4 cla4
// groups, then a flat lookahead across the group generate/propagate terms.
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset (clears all outputs)
//   bus : adder_if.slave
//         in_valid/a/b/sub in; s/out_valid/cout/ovf/zero out (registered)
// WIDTH must be a multiple of 4 in the range 4..64.
// ----------------------------------------------------------------------------
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic   clk,
    input  logic   rst,
    adder_if.slave bus
);

    localparam int NG = WIDTH / GROUP;

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic [NG-1:0]    w_gg;
    logic [NG-1:0]    w_gp;
    logic [NG:0]      w_gcarry;
    logic             w_cout;
    logic             w_cmsb;
    logic             w_ovf;
    logic             w_zero;

    logic [WIDTH-1:0] r_s;
    logic             r_valid;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    // Subtraction is a + ~b + 1; the +1 enters as the carry into group 0.
    assign w_b_eff = bus.sub ? ~bus.b : bus.b;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla4 u_cla4 (
            .i_a   (bus.a[gi*GROUP +: GROUP]),
            .i_b   (w_b_eff[gi*GROUP +: GROUP]),
            .i_cin (w_gcarry[gi]),
            .o_sum (w_sum[gi*GROUP +: GROUP]),
            .o_gg  (w_gg[gi]),
            .o_gp  (w_gp[gi])
        );
    end

    // Second-level lookahead: every group carry is a sum of products of the
    // group G/P terms and the carry-in, so no carry ripples group to group.
    always_comb begin : p_lookahead
        logic v_term;
        v_term      = 1'b0;
        w_gcarry    = '0;
        w_gcarry[0] = bus.sub;
        for (int k = 1; k <= NG; k++) begin
            for (int j = 0; j < k; j++) begin
                v_term = w_gg[j];
                for (int m = j + 1; m < k; m++) begin
                    v_term = v_term & w_gp[m];
                end
                w_gcarry[k] = w_gcarry[k] | v_term;
            end
            v_term = bus.sub;
            for (int m = 0; m < k; m++) begin
                v_term = v_term & w_gp[m];
            end
            w_gcarry[k] = w_gcarry[k] | v_term;
        end
    end

    assign w_cout = w_gcarry[NG];

    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
    assign w_cmsb = bus.a[WIDTH-1] ^ w_b_eff[WIDTH-1] ^ w_sum[WIDTH-1];
    assign w_ovf  = w_cmsb ^ w_cout;
    assign w_zero = (w_sum == '0);

    // Result registers load only on accepted operations, so anything on a/b
    // while in_valid is low never reaches the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s     <= '0;
            r_valid <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s    <= w_sum;
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
                r_zero <= w_zero;
            end
        end
    end

    assign bus.s         = r_s;
    assign bus.out_valid = r_valid;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;

endmodule : adder

// File: tb/tb_adder.sv
// ----------------------------------------------------------------------------
// tb_adder
// Self-checking bench for adder (WIDTH = 32). Expected results come from an
// arithmetic reference model; outputs are sampled 1 time unit after each
// rising edge.
// ----------------------------------------------------------------------------
module tb_adder;

    localparam int W = 32;

    logic clk;
    logic rst;

    adder_if #(.WIDTH(W)) bus ();

    adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    logic [W-1:0] exp_s;
    logic         exp_valid;
    logic         exp_cout;
    logic         exp_ovf;
    logic         exp_zero;

    // Reference: plain unsigned/signed arithmetic rules, not a carry chain.
    task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub);
        logic [W:0] full;
        if (!sub) begin
            full     = {1'b0, a} + {1'b0, b};
            exp_s    = full[W-1:0];
            exp_cout = full[W];
            exp_ovf  = (a[W-1] == b[W-1]) && (exp_s[W-1] != a[W-1]);
        end else begin
            exp_s    = a - b;
            exp_cout = (a >= b);
            exp_ovf  = (a[W-1] != b[W-1]) && (exp_s[W-1] != a[W-1]);
        end
        exp_zero = (exp_s == '0);
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(exp_valid));
        check({tag, ".s"},         64'(bus.s),         64'(exp_s));
        check({tag, ".cout"},      64'(bus.cout),      64'(exp_cout));
        check({tag, ".ovf"},       64'(bus.ovf),       64'(exp_ovf));
        check({tag, ".zero"},      64'(bus.zero),      64'(exp_zero));
    endtask

    task automatic model_reset();
        exp_s     = '0;
        exp_valid = 1'b0;
        exp_cout  = 1'b0;
        exp_ovf   = 1'b0;
        exp_zero  = 1'b0;
    endtask

    // Drive one cycle, then sample just after the edge.
    task automatic step(input string tag, input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic sub);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.sub      = sub;
        @(posedge clk);
        #1;
        if (v) begin
            ref_op(a, b, sub);
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        check_all(tag);
    endtask

    initial begin
        logic         v;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        n_vec = 0;
        n_err = 0;
        model_reset();

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.sub      = 1'b0;

        #3;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases, with literal sums checked alongside the model.
        step("d_small", 1'b1, 32'h0000_0000, 32'h0000_0004, 1'b0);
        check("d_small.s_lit", 64'(bus.s), 64'h0000_0004);

        step("d_mid", 1'b1, 32'hFA00_0004, 32'h0000_0004, 1'b0);
        check("d_mid.s_lit", 64'(bus.s), 64'hFA00_0008);

        step("d_carry", 1'b1, 32'hFA00_0004, 32'hFF00_0008, 1'b0);
        check("d_carry.s_lit", 64'(bus.s), 64'hF900_000C);
        check("d_carry.cout_lit", 64'(bus.cout), 64'h1);

        step("d_sovf", 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        check("d_sovf.s_lit", 64'(bus.s), 64'h8000_0000);
        check("d_sovf.ovf_lit", 64'(bus.ovf), 64'h1);

        step("d_wrap", 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        check("d_wrap.zero_lit", 64'(bus.zero), 64'h1);
        check("d_wrap.cout_lit", 64'(bus.cout), 64'h1);

        step("d_hold", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

        step("d_sub_eq", 1'b1, 32'h0000_0005, 32'h0000_0005, 1'b1);
        check("d_sub_eq.zero_lit", 64'(bus.zero), 64'h1);

        step("d_sub_brw", 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b1);
        check("d_sub_brw.s_lit", 64'(bus.s), 64'hFFFF_FFFF);
        check("d_sub_brw.cout_lit", 64'(bus.cout), 64'h0);

        step("d_sub_ovf", 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1);

        // 1000 random operations with random idle gaps carrying junk operands.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                step("gap", 1'b0, $urandom, $urandom, 1'($urandom));
            end
            v  = 1'b1;
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: rb = ~ra + 32'd1;
                2: ra = 32'hFFFF_FFFF;
                3: rb = 32'h8000_0000;
                default: ;
            endcase
            step("rand", v, ra, rb, rs);
        end

        // Asynchronous reset between edges while a result is valid.
        step("pre_rst", 1'b1, 32'h1357_9BDF, 32'h2468_ACE0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        bus.in_valid = 1'b1;
        bus.a        = 32'hDEAD_BEEF;
        bus.b        = 32'h0000_0001;
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        step("post_rst0", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        step("post_rst1", 1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0);
        step("post_rst2", 1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_adder
